// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch slice: reset PC, NOP encoding,
// queue depth and PC increment, plus a small alignment helper.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
  localparam int          FETCH_QUEUE_DEPTH = 2;
  localparam int          PC_STEP           = 4;

  // A redirect target is word aligned only when its two low bits are clear.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Two-entry FIFO holding {pc, instr} pairs between the ROM and decode.
// Push and pop in the same cycle are legal even when full; flush empties it.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_next;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
  end

  // When full, a simultaneous push lands in the slot the pop is vacating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == DEPTH_CNT);

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC generator and fetch buffer feeding decode from the program ROM.
// Absorbs decode back-pressure via a 2-entry queue and flushes on redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                    QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_PC_i,
  output logic [DATA_WIDTH-1:0] Imem_Address_o,
  input  logic [DATA_WIDTH-1:0] Imem_Instruction_i,
  input  logic                  Ready_i,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PC_plus4_o,
  output logic                  Misaligned_o
);

  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);
  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INSTR);

  logic [DATA_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0]   pc_next;
  logic                    push;
  logic                    pop;
  logic [2*DATA_WIDTH-1:0] q_wdata;
  logic [2*DATA_WIDTH-1:0] q_rdata;
  logic [1:0]              q_count;
  logic                    q_empty;
  logic                    q_full;
  logic [DATA_WIDTH-1:0]   head_pc;
  logic [DATA_WIDTH-1:0]   head_instr;

  assign Imem_Address_o = pc;
  assign pop  = Valid_o & Ready_i;
  assign push = !Redirect_i & !Stall_i & (!q_full | pop);
  assign q_wdata = {pc, Imem_Instruction_i};

  always_comb begin
    pc_next = pc;
    if (Redirect_i) begin
      pc_next = {Redirect_PC_i[DATA_WIDTH-1:2], 2'b00};
    end else if (push) begin
      pc_next = pc + STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      Misaligned_o <= 1'b0;
    end else begin
      pc           <= pc_next;
      Misaligned_o <= Redirect_i & is_misaligned(Redirect_PC_i[1:0]);
    end
  end

  fetch_queue #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (Redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // Head outputs come only from queue state, never straight from the ROM.
  assign head_pc    = q_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_instr = q_rdata[DATA_WIDTH-1:0];
  assign Valid_o       = !q_empty;
  assign Instruction_o = Valid_o ? head_instr : NOP;
  assign PC_o          = Valid_o ? head_pc : '0;
  assign PC_plus4_o    = Valid_o ? head_pc + STEP : '0;

  queue_count_in_range : assert property (
    @(posedge clk) disable iff (!reset) q_count <= 2'(QUEUE_DEPTH)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based reference
// model of the fetch rules, plus directed reset/stall/redirect scenarios.
module tb_instruction_fetch_unit;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        Stall_i;
  logic        Redirect_i;
  logic [31:0] Redirect_PC_i;
  logic [31:0] Imem_Address_o;
  logic [31:0] Imem_Instruction_i;
  logic        Ready_i;
  logic        Valid_o;
  logic [31:0] Instruction_o;
  logic [31:0] PC_o;
  logic [31:0] PC_plus4_o;
  logic        Misaligned_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mPc;
  logic [31:0] mQ[$];
  logic        mMis;

  instruction_fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .Stall_i            (Stall_i),
    .Redirect_i         (Redirect_i),
    .Redirect_PC_i      (Redirect_PC_i),
    .Imem_Address_o     (Imem_Address_o),
    .Imem_Instruction_i (Imem_Instruction_i),
    .Ready_i            (Ready_i),
    .Valid_o            (Valid_o),
    .Instruction_o      (Instruction_o),
    .PC_o               (PC_o),
    .PC_plus4_o         (PC_plus4_o),
    .Misaligned_o       (Misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: each word holds 0xA000_0000 | its word index from the text base.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    return 32'hA000_0000 | (idx & 32'h0FFF_FFFF);
  endfunction

  assign Imem_Instruction_i = romWord(Imem_Address_o);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic redir,
                               input logic [31:0] rpc, input logic ready);
    Stall_i       = stall;
    Redirect_i    = redir;
    Redirect_PC_i = rpc;
    Ready_i       = ready;
  endtask

  task automatic modelReset();
    mQ.delete();
    mPc  = BASE;
    mMis = 1'b0;
  endtask

  // One clock edge of the fetch rules, using the inputs as they stand now.
  task automatic modelEdge();
    int  sz;
    bit  mpop;
    logic [31:0] dropped;
    sz   = mQ.size();
    mpop = (sz > 0) && Ready_i;
    if (Redirect_i) begin
      mQ.delete();
      mPc  = {Redirect_PC_i[31:2], 2'b00};
      mMis = |Redirect_PC_i[1:0];
    end else begin
      mMis = 1'b0;
      if (mpop) dropped = mQ.pop_front();
      if (!Stall_i && (sz < 2 || mpop)) begin
        mQ.push_back(mPc);
        mPc = mPc + 32'd4;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    bit v;
    v = mQ.size() > 0;
    checkOutput({tag, ".valid"}, {31'b0, Valid_o}, {31'b0, v});
    checkOutput({tag, ".addr"}, Imem_Address_o, mPc);
    checkOutput({tag, ".mis"}, {31'b0, Misaligned_o}, {31'b0, mMis});
    checkOutput({tag, ".pc"}, PC_o, v ? mQ[0] : 32'h0);
    checkOutput({tag, ".pc4"}, PC_plus4_o, v ? mQ[0] + 32'd4 : 32'h0);
    checkOutput({tag, ".instr"}, Instruction_o, v ? romWord(mQ[0]) : NOPI);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll(tag);
  endtask

  // Reset asserted between edges must clear the outputs without waiting for a clock.
  task automatic asyncReset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".asyncValid"}, {31'b0, Valid_o}, 32'd0);
    checkOutput({tag, ".asyncAddr"}, Imem_Address_o, BASE);
    @(negedge clk);
    checkAll({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    reset = 1'b1;

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("stream");

    asyncReset("rst1");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("backpressure");
    checkOutput("frozenAddr", Imem_Address_o, 32'h0040_0008);
    checkOutput("frozenHead", PC_o, 32'h0040_0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) cycle("drain");

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("fill");
    applyStimulus(1'b0, 1'b1, 32'h0040_0040, 1'b0);
    cycle("redirFull");
    checkOutput("redirBubble", {31'b0, Valid_o}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    cycle("redirTarget");
    checkOutput("redirInstr", Instruction_o, 32'hA000_0010);
    for (int i = 0; i < 2; i++) cycle("redirAfter");

    applyStimulus(1'b0, 1'b1, 32'h0040_0042, 1'b1);
    cycle("misRedir");
    checkOutput("misPulse", {31'b0, Misaligned_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("misAfter");

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("stall");
    checkOutput("stallNop", Instruction_o, NOPI);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("unstall");

    applyStimulus(1'b1, 1'b1, 32'h0040_0100, 1'b1);
    cycle("redirStall");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) cycle("redirStallAfter");

    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    cycle("wrapRedir");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("wrap");

    asyncReset("rst2");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        asyncReset("rndRst");
      end else begin
        applyStimulus($urandom_range(0, 4) == 0,
                      $urandom_range(0, 9) == 0,
                      BASE + ($urandom & 32'h0000_0FFF),
                      $urandom_range(0, 2) != 0);
        cycle("random");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
